// File: rtl/vector_op_engine_if.sv
// Command, vector-memory read and result channels of vector_op_engine.
// Result handshake: res_valid/res_data stay stable until a cycle with res_valid && res_ready, which is the transfer.
interface vector_op_engine_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
);
    logic [2:0]        cmd;
    logic              cmd_valid;
    logic [ADDR_W-1:0] bram_a_read_addr;
    logic [ADDR_W-1:0] bram_b_read_addr;
    logic [DATA_W-1:0] bram_a_dout;
    logic [DATA_W-1:0] bram_b_dout;
    logic [31:0]       res_data;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
    logic              op_done;
    logic [2:0]        dbg_state;

    // master: the engine; slave: decoder, memories and result sink around it
    modport master (
        input  cmd, cmd_valid, bram_a_dout, bram_b_dout, res_ready,
        output bram_a_read_addr, bram_b_read_addr, res_data, res_valid,
        output busy, op_done, dbg_state
    );

    modport slave (
        output cmd, cmd_valid, bram_a_dout, bram_b_dout, res_ready,
        input  bram_a_read_addr, bram_b_read_addr, res_data, res_valid,
        input  busy, op_done, dbg_state
    );
endinterface

// File: rtl/vector_op_engine.sv
// Element-wise (SUM/AVG) and reducing (MAN/DOT) operations over two vector memories,
// one element per FETCH/WAIT pass, results streamed out over a valid/ready channel.
module vector_op_engine #(
    parameter int N_ELEMS      = 1024,
    parameter int DATA_W       = 10,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    vector_op_engine_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0]        OP_SUM   = 3'd1;
    localparam logic [2:0]        OP_AVG   = 3'd2;
    localparam logic [2:0]        OP_MAN   = 3'd3;
    localparam logic [2:0]        OP_DOT   = 3'd4;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEMS - 1);
    localparam logic [1:0]        LAT_LAST = 2'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       res_q, res_d;
    logic [1:0]        wcnt_q, wcnt_d;

    logic        cmd_legal;
    logic        is_reduce;
    logic [31:0] a_ext, b_ext;
    logic [31:0] elem_sum, elem_res, term;

    assign cmd_legal = (bus.cmd == OP_SUM) || (bus.cmd == OP_AVG) ||
                       (bus.cmd == OP_MAN) || (bus.cmd == OP_DOT);
    assign is_reduce = (op_q == OP_MAN) || (op_q == OP_DOT);

    // Operands widened first so the sum keeps its carry and |a-b| never wraps
    assign a_ext    = 32'(bus.bram_a_dout);
    assign b_ext    = 32'(bus.bram_b_dout);
    assign elem_sum = a_ext + b_ext;
    assign elem_res = (op_q == OP_AVG) ? (elem_sum >> 1) : elem_sum;
    assign term     = (op_q == OP_DOT) ? (a_ext * b_ext) :
                      ((a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_legal) begin
                    op_d    = bus.cmd;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == LAT_LAST) begin
                    if (is_reduce) begin
                        acc_d = acc_q + term;
                        if (idx_q < LAST_IDX) begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = FETCH;
                        end else begin
                            res_d   = acc_q + term;
                            state_d = SEND;
                        end
                    end else begin
                        res_d   = elem_res;
                        state_d = SEND;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            SEND: begin
                if (bus.res_ready) begin
                    if (!is_reduce && (idx_q < LAST_IDX)) begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.bram_a_read_addr = idx_q;
    assign bus.bram_b_read_addr = idx_q;
    assign bus.res_data         = res_q;
    assign bus.res_valid        = (state_q == SEND);
    assign bus.busy             = (state_q != IDLE);
    assign bus.op_done          = (state_q == DONE);
    assign bus.dbg_state        = state_q;
endmodule

// File: tb/tb_vector_op_engine.sv
// Scoreboard bench for vector_op_engine: one instance with 1-cycle and one with 2-cycle memory latency.
module tb_vector_op_engine;
    localparam int N  = 1024;
    localparam int DW = 10;
    localparam int AW = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vector_op_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    vector_op_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    vector_op_engine #(.N_ELEMS(N), .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    vector_op_engine #(.N_ELEMS(N), .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    // ---------------- vector memories ----------------
    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];
    logic [DW-1:0] a2_p, b2_p;

    always @(posedge clk) begin
        bus1.bram_a_dout <= mem_a[bus1.bram_a_read_addr];
        bus1.bram_b_dout <= mem_b[bus1.bram_b_read_addr];
        a2_p             <= mem_a[bus2.bram_a_read_addr];
        b2_p             <= mem_b[bus2.bram_b_read_addr];
        bus2.bram_a_dout <= a2_p;
        bus2.bram_b_dout <= b2_p;
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp1_q[$];
    logic [31:0] exp2_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int done1 = 0;
    int done2 = 0;
    int rx1   = 0;
    bit rand_ready = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    // ---------------- result sink ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus1.res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic        stalled1;
        logic [31:0] held1;
        stalled1 = 1'b0;
        held1    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled1 = 1'b0;
            end else begin
                if (bus1.op_done) done1++;
                if (bus2.op_done) done2++;
                if (stalled1 && !bus1.res_valid) fail_now("valid_dropped_while_stalled");
                if (bus1.res_valid) begin
                    if (stalled1) check("res_data_stable", bus1.res_data, held1);
                    if (bus1.res_ready) begin
                        if (exp1_q.size() == 0) fail_now("unexpected_result_dut1");
                        else check("result_dut1", bus1.res_data, exp1_q.pop_front());
                        rx1++;
                        stalled1 = 1'b0;
                    end else begin
                        stalled1 = 1'b1;
                        held1    = bus1.res_data;
                    end
                end else begin
                    stalled1 = 1'b0;
                end
                if (bus2.res_valid && bus2.res_ready) begin
                    if (exp2_q.size() == 0) fail_now("unexpected_result_dut2");
                    else check("result_dut2", bus2.res_data, exp2_q.pop_front());
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic push_exp(input bit which, input logic [31:0] v);
        if (which) exp2_q.push_back(v);
        else       exp1_q.push_back(v);
    endtask

    task automatic model(input bit which, input int op);
        longint acc = 0;
        for (int i = 0; i < N; i++) begin
            int a = int'(mem_a[i]);
            int b = int'(mem_b[i]);
            case (op)
                1: push_exp(which, 32'(a + b));
                2: push_exp(which, 32'((a + b) / 2));
                3: acc += (a > b) ? (a - b) : (b - a);
                4: acc += longint'(a) * longint'(b);
                default: ;
            endcase
        end
        if (op == 3 || op == 4) push_exp(which, 32'(acc));
    endtask

    // ---------------- drivers ----------------
    task automatic issue(input bit which, input logic [2:0] op);
        @(posedge clk);
        #1;
        if (which) begin bus2.cmd = op; bus2.cmd_valid = 1'b1; end
        else       begin bus1.cmd = op; bus1.cmd_valid = 1'b1; end
        @(posedge clk);
        #1;
        bus1.cmd_valid = 1'b0;
        bus2.cmd_valid = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin mem_a[i] = DW'(i);    mem_b[i] = DW'(1023 - i);  end
                1: begin mem_a[i] = DW'(i);    mem_b[i] = DW'((i + 3) % 1024); end
                2: begin mem_a[i] = DW'(1023); mem_b[i] = DW'(1023);      end
                3: begin mem_a[i] = DW'(3);    mem_b[i] = DW'(10);        end
                default: begin
                    mem_a[i] = DW'($urandom_range(0, 1023));
                    mem_b[i] = DW'($urandom_range(0, 1023));
                end
            endcase
        end
    endtask

    task automatic wait_done(input bit which, input string name);
        int start;
        int k;
        start = which ? done2 : done1;
        k = 0;
        while (((which ? done2 : done1) == start) && (k < 20000)) begin
            @(negedge clk);
            #1;
            k++;
        end
        if ((which ? done2 : done1) == start) begin
            fail_now({name, "_timeout"});
            exp1_q.delete();
            exp2_q.delete();
        end else begin
            check({name, "_busy_during_done"}, 32'(which ? bus2.busy : bus1.busy), 32'd1);
            @(negedge clk);
            #1;
            check({name, "_busy_after_done"}, 32'(which ? bus2.busy : bus1.busy), 32'd0);
            check({name, "_op_done_one_cycle"}, 32'(which ? bus2.op_done : bus1.op_done), 32'd0);
            check({name, "_op_done_count"}, 32'(which ? done2 : done1), 32'(start + 1));
            check({name, "_results_left"}, 32'(which ? exp2_q.size() : exp1_q.size()), 32'd0);
        end
    endtask

    task automatic run(input bit which, input int mode, input logic [2:0] op, input string name);
        fill(mode);
        model(which, int'(op));
        issue(which, op);
        check({name, "_busy_after_cmd"}, 32'(which ? bus2.busy : bus1.busy), 32'd1);
        wait_done(which, name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_res_valid"}, 32'(bus1.res_valid), 32'd0);
        check({name, "_busy"},      32'(bus1.busy), 32'd0);
        check({name, "_op_done"},   32'(bus1.op_done), 32'd0);
        check({name, "_addr_a"},    32'(bus1.bram_a_read_addr), 32'd0);
        check({name, "_addr_b"},    32'(bus1.bram_b_read_addr), 32'd0);
        check({name, "_res_data"},  bus1.res_data, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int k;
        bus1.cmd = 3'd0; bus1.cmd_valid = 1'b0;
        bus2.cmd = 3'd0; bus2.cmd_valid = 1'b0;
        bus2.res_ready = 1'b1;
        fill(3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // illegal opcode in idle is ignored
        d0 = done1;
        issue(1'b0, 3'd7);
        check("illegal_cmd_busy", 32'(bus1.busy), 32'd0);
        repeat (4) @(negedge clk);
        check("illegal_cmd_no_done", 32'(done1), 32'(d0));

        // SUM with a second SUM strobed while busy
        fill(0);
        model(1'b0, 1);
        issue(1'b0, 3'd1);
        check("sum_busy_after_cmd", 32'(bus1.busy), 32'd1);
        repeat (20) @(posedge clk);
        issue(1'b0, 3'd1);
        wait_done(1'b0, "sum");

        rand_ready = 1'b1;
        run(1'b0, 1, 3'd2, "avg_stall");
        rand_ready = 1'b0;
        run(1'b0, 2, 3'd4, "dot_max");
        run(1'b0, 3, 3'd3, "man_lat1");
        run(1'b1, 3, 3'd3, "man_lat2");

        // reset in the middle of a SUM
        fill(4);
        model(1'b0, 1);
        rx1 = 0;
        issue(1'b0, 3'd1);
        k = 0;
        while (rx1 < 500 && k < 5000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (rx1 < 500) fail_now("reset_mid_sum_never_reached_500");
        #2;
        d0 = done1;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp1_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("async_reset_no_done", 32'(done1), 32'(d0));
        check("async_reset_idle", 32'(bus1.busy), 32'd0);

        run(1'b0, 4, 3'd4, "dot_after_reset");
        run(1'b0, 4, 3'd3, "man_rand");
        rand_ready = 1'b1;
        run(1'b0, 4, 3'd2, "avg_rand");
        rand_ready = 1'b0;
        run(1'b1, 4, 3'd4, "dot_lat2_rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
